// File: rtl/frame_mon_pkg.sv
// Shared types and CRC helper for the frame CRC monitor.
package frame_mon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // CRC-16-CCITT over the low nbits of data, MSB first, in one step.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic [15:0] data,
                                             input int          nbits);
    logic [15:0] c;
    logic        fb;
    c  = crc;
    fb = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (i < nbits) begin
        fb = c[15] ^ data[i];
        c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_crc_monitor_if.sv
// Video input triple plus frame report bundle for frame_crc_monitor.
// master = video source / report consumer, slave = the monitor.
interface frame_crc_monitor_if #(
  parameter int RGB_W  = 3,
  parameter int X_W    = 9,
  parameter int Y_W    = 9,
  parameter int FCNT_W = 16
);
  logic                 hsync;
  logic                 vsync;
  logic [RGB_W-1:0]     rgb;
  logic                 frame_valid;
  logic [15:0]          frame_crc;
  logic [Y_W-1:0]       frame_lines;
  logic [X_W-1:0]       frame_width;
  logic                 width_mismatch;
  logic                 frame_changed;
  logic [FCNT_W-1:0]    frame_count;
  logic [7:0][15:0]     hist;

  modport master (
    output hsync, vsync, rgb,
    input  frame_valid, frame_crc, frame_lines, frame_width,
           width_mismatch, frame_changed, frame_count, hist
  );

  modport slave (
    input  hsync, vsync, rgb,
    output frame_valid, frame_crc, frame_lines, frame_width,
           width_mismatch, frame_changed, frame_count, hist
  );
endinterface

// File: rtl/video_pos_tracker.sv
// Input registers, sync edge detect, pixel phase and x/y geometry.
// Frame-level counts are exported as their next values so a line that
// closes in the same cycle as the frame is included in the report.
module video_pos_tracker #(
  parameter int RGB_W   = 3,
  parameter int PIX_DIV = 2,
  parameter int X_W     = 9,
  parameter int Y_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [RGB_W-1:0] rgb,
  input  logic             clr,
  output logic             sample,
  output logic             line_end,
  output logic             frame_end,
  output logic [RGB_W-1:0] pix,
  output logic [Y_W-1:0]   lines_nx,
  output logic [X_W-1:0]   width_nx,
  output logic             mismatch_nx
);
  localparam int PH_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic             hs_q, vs_q, hs_d, vs_d;
  logic [RGB_W-1:0] rgb_q;
  logic [PH_W-1:0]  phase, phase_eff;
  logic             hs_rise;
  logic [X_W-1:0]   x_cnt, x_nx, first_w;
  logic [Y_W-1:0]   y_cnt;
  logic             mm;

  // register raw inputs once, keep previous values for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b0; vs_q <= 1'b0; hs_d <= 1'b0; vs_d <= 1'b0; rgb_q <= '0;
    end else begin
      hs_q <= hsync; vs_q <= vsync; rgb_q <= rgb;
      hs_d <= hs_q;  vs_d <= vs_q;
    end
  end

  assign hs_rise   = hs_q & ~hs_d;
  assign line_end  = hs_d & ~hs_q;
  assign frame_end = vs_d & ~vs_q;
  assign pix       = rgb_q;

  // a rising hsync realigns the pixel phase to the start of the line
  assign phase_eff = hs_rise ? '0 : phase;
  assign sample    = hs_q & vs_q & (phase_eff == '0);

  // phase counter 0..PIX_DIV-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase <= '0;
    else       phase <= (phase_eff == PH_W'(PIX_DIV-1)) ? '0 : phase_eff + 1'b1;
  end

  // next-state of pixel and line geometry
  always_comb begin
    x_nx        = x_cnt;
    lines_nx    = y_cnt;
    width_nx    = first_w;
    mismatch_nx = mm;
    if (sample && x_cnt != '1) x_nx = x_cnt + 1'b1;
    if (line_end) begin
      x_nx = '0;
      if (x_cnt != '0) begin
        if (y_cnt != '1) lines_nx = y_cnt + 1'b1;
        if (y_cnt == '0)            width_nx    = x_cnt;
        else if (x_cnt != first_w)  mismatch_nx = 1'b1;
      end
    end
  end

  // geometry accumulators, cleared by the frame FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt <= '0; y_cnt <= '0; first_w <= '0; mm <= 1'b0;
    end else if (clr) begin
      x_cnt <= '0; y_cnt <= '0; first_w <= '0; mm <= 1'b0;
    end else begin
      x_cnt <= x_nx; y_cnt <= lines_nx; first_w <= width_nx; mm <= mismatch_nx;
    end
  end
endmodule

// File: rtl/frame_crc_monitor.sv
// Video output monitor: per-frame CRC-16, geometry and a one-cycle report.
// Optional per-colour histogram enabled by macro FRAME_CRC_HIST_EN.
module frame_crc_monitor
  import frame_mon_pkg::*;
#(
  parameter int RGB_W   = 3,
  parameter int PIX_DIV = 2,
  parameter int X_W     = 9,
  parameter int Y_W     = 9,
  parameter int FCNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  frame_crc_monitor_if.slave  vif
);
  state_t             state, state_nx;
  logic               clr, latch_en, fv;
  logic               sample, line_end, frame_end;
  logic [RGB_W-1:0]   pix;
  logic [Y_W-1:0]     lines_nx;
  logic [X_W-1:0]     width_nx;
  logic               mismatch_nx;
  logic [15:0]        crc;
  logic [15:0]        r_crc;
  logic [Y_W-1:0]     r_lines;
  logic [X_W-1:0]     r_width;
  logic               r_mm, r_chg, seen;
  logic [FCNT_W-1:0]  r_cnt;

  video_pos_tracker #(
    .RGB_W(RGB_W), .PIX_DIV(PIX_DIV), .X_W(X_W), .Y_W(Y_W)
  ) u_pos (
    .clk(clk), .reset(reset),
    .hsync(vif.hsync), .vsync(vif.vsync), .rgb(vif.rgb),
    .clr(clr),
    .sample(sample), .line_end(line_end), .frame_end(frame_end),
    .pix(pix), .lines_nx(lines_nx), .width_nx(width_nx),
    .mismatch_nx(mismatch_nx)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state: the first frame end only arms the monitor
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_end) state_nx = RUN;
      RUN:     if (frame_end) state_nx = REPORT;
      REPORT:  state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // outputs: report values are captured on the frame-end edge so the
  // REPORT cycle already sees cleared accumulators for the next frame
  always_comb begin
    clr      = 1'b0;
    latch_en = 1'b0;
    fv       = 1'b0;
    case (state)
      IDLE:    clr = 1'b1;
      RUN:     if (frame_end) begin latch_en = 1'b1; clr = 1'b1; end
      REPORT:  fv = 1'b1;
      default: clr = 1'b1;
    endcase
  end

  // running frame CRC
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       crc <= CRC_INIT;
    else if (clr)    crc <= CRC_INIT;
    else if (sample) crc <= crc16_step(crc, 16'(pix), RGB_W);
  end

  // report latches, held between reports
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= '0; r_lines <= '0; r_width <= '0; r_mm <= 1'b0;
      r_chg <= 1'b0; r_cnt <= '0; seen <= 1'b0;
    end else if (latch_en) begin
      r_crc   <= crc;
      r_lines <= lines_nx;
      r_width <= width_nx;
      r_mm    <= mismatch_nx;
      r_chg   <= seen & (crc != r_crc);
      r_cnt   <= r_cnt + 1'b1;
      seen    <= 1'b1;
    end
  end

  assign vif.frame_valid    = fv;
  assign vif.frame_crc      = r_crc;
  assign vif.frame_lines    = r_lines;
  assign vif.frame_width    = r_width;
  assign vif.width_mismatch = r_mm;
  assign vif.frame_changed  = r_chg;
  assign vif.frame_count    = r_cnt;

`ifdef FRAME_CRC_HIST_EN
  for (genvar g = 0; g < 8; g++) begin : g_hist
    logic [15:0] cnt, held;
    // saturating colour counter, snapshotted at the report
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0; held <= '0;
      end else begin
        if (latch_en) held <= cnt;
        if (clr) cnt <= '0;
        else if (sample && pix[2:0] == 3'(g) && cnt != '1) cnt <= cnt + 1'b1;
      end
    end
    assign vif.hist[g] = held;
  end
`else
  assign vif.hist = '0;
`endif
endmodule

// File: tb/tb_frame_crc_monitor.sv
// Self-checking bench for frame_crc_monitor: table of frames + scoreboard.
module tb_frame_crc_monitor;
  localparam int RGB_W = 3, PIX_DIV = 2, X_W = 9, Y_W = 9, FCNT_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_crc_monitor_if #(.RGB_W(RGB_W), .X_W(X_W), .Y_W(Y_W), .FCNT_W(FCNT_W)) vif();

  frame_crc_monitor #(
    .RGB_W(RGB_W), .PIX_DIV(PIX_DIV), .X_W(X_W), .Y_W(Y_W), .FCNT_W(FCNT_W)
  ) dut (.clk(clk), .reset(reset), .vif(vif));

  typedef struct {
    int nl, np, sl, sp, pat;
    bit no_hs, same;
    logic [8:0] lines, width;
    bit mm, chg;
  } vec_t;

  typedef struct {
    logic [15:0] crc;
    logic [8:0]  lines, width;
    logic        mm, chg;
    logic [15:0] cnt;
    logic [7:0][15:0] hist;
  } rpt_t;

  rpt_t        sb[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, vs_fall_cyc = 0, n_reports = 0;
  logic [15:0] m_cnt = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bit-serial CRC-16-CCITT with the 3-bit symbol aligned at the top
  function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [2:0] d);
    logic [15:0] r;
    r = c ^ {d, 13'b0};
    for (int k = 0; k < 3; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [2:0] pix_val(input int pat, input int x, input int y);
    case (pat)
      0:       return 3'd5;
      1:       return (x == 5 && y == 3) ? 3'd2 : 3'd5;
      2:       return 3'((x + y) % 8);
      default: return (y < 5) ? 3'd0 : 3'd7;
    endcase
  endfunction

  function automatic vec_t mk(input int nl, np, sl, sp, pat, input bit no_hs, same,
                              input int lines, width, input bit mm, chg);
    vec_t v;
    v.nl = nl; v.np = np; v.sl = sl; v.sp = sp; v.pat = pat;
    v.no_hs = no_hs; v.same = same;
    v.lines = 9'(lines); v.width = 9'(width); v.mm = mm; v.chg = chg;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_line(input int np, input int y, input int pat, input bit keep_hs,
                            inout logic [15:0] crc, inout int h[8]);
    for (int x = 0; x < np; x++) begin
      logic [2:0] p;
      p = pix_val(pat, x, y);
      vif.hsync = 1'b1; vif.rgb = p;
      crc = model_crc(crc, p);
      h[p]++;
      tick(PIX_DIV);
    end
    if (!keep_hs) begin
      vif.hsync = 1'b0; tick(4);
    end
  endtask

  task automatic drive_frame(input vec_t v, input bit push);
    logic [15:0] crc;
    int h[8];
    rpt_t e;
    crc = 16'hFFFF;
    for (int i = 0; i < 8; i++) h[i] = 0;
    vif.vsync = 1'b1; vif.hsync = 1'b0; tick(4);
    if (v.no_hs) tick(40);
    else
      for (int y = 0; y < v.nl; y++)
        drive_line((y == v.sl) ? v.sp : v.np, y, v.pat, v.same && (y == v.nl - 1), crc, h);
    if (push) begin
      m_cnt++;
      e.crc = crc; e.lines = v.lines; e.width = v.width; e.mm = v.mm; e.chg = v.chg;
      e.cnt = m_cnt;
      for (int i = 0; i < 8; i++) begin
`ifdef FRAME_CRC_HIST_EN
        e.hist[i] = 16'(h[i]);
`else
        e.hist[i] = 16'd0;
`endif
      end
      sb.push_back(e);
    end
    vif.hsync = 1'b0; vif.vsync = 1'b0; vs_fall_cyc = cyc;
    tick(8);
    vif.vsync = 1'b1;
  endtask

  // scoreboard: every report strobe pops one expected frame
  always @(negedge clk) begin
    if (!reset && vif.frame_valid) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_report: frame_valid=1 with no frame expected (count=%0d)", vif.frame_count);
      end else begin
        rpt_t e;
        e = sb.pop_front();
        n_reports++;
        check("frame_crc",      128'(vif.frame_crc),      128'(e.crc));
        check("frame_lines",    128'(vif.frame_lines),    128'(e.lines));
        check("frame_width",    128'(vif.frame_width),    128'(e.width));
        check("width_mismatch", 128'(vif.width_mismatch), 128'(e.mm));
        check("frame_changed",  128'(vif.frame_changed),  128'(e.chg));
        check("frame_count",    128'(vif.frame_count),    128'(e.cnt));
        check("hist",           128'(vif.hist),           128'(e.hist));
        check("latency",        128'(cyc - vs_fall_cyc),  128'(2));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    vec_t v;
    logic [15:0] dummy;
    int dh[8];
    // nl np sl sp pat no_hs same lines width mm chg
    tbl[0] = mk(10, 8, -1, 0, 2, 0, 0, 10, 8, 0, 0);
    tbl[1] = mk(10, 8, -1, 0, 2, 0, 0, 10, 8, 0, 0);
    tbl[2] = mk(10, 8, -1, 0, 2, 0, 0, 10, 8, 0, 0);
    tbl[3] = mk(10, 8, -1, 0, 2, 1, 0,  0, 0, 0, 1);
    tbl[4] = mk(10, 8, -1, 0, 0, 0, 0, 10, 8, 0, 1);
    tbl[5] = mk(10, 8, -1, 0, 0, 0, 0, 10, 8, 0, 0);
    tbl[6] = mk(10, 8, -1, 0, 1, 0, 0, 10, 8, 0, 1);
    tbl[7] = mk(10, 8,  4, 7, 2, 0, 0, 10, 8, 1, 1);
    tbl[8] = mk(10, 8, -1, 0, 2, 0, 0, 10, 8, 0, 1);
    tbl[9] = mk(10, 8, -1, 0, 3, 0, 0, 10, 8, 0, 1);

    vif.hsync = 1'b0; vif.vsync = 1'b0; vif.rgb = '0;
    dummy = 16'hFFFF;
    for (int i = 0; i < 8; i++) dh[i] = 0;
    tick(3);
    check("rst_frame_valid", 128'(vif.frame_valid), 128'(0));
    check("rst_frame_crc",   128'(vif.frame_crc),   128'(0));
    check("rst_frame_count", 128'(vif.frame_count), 128'(0));
    check("rst_geometry", 128'({vif.frame_lines, vif.frame_width, vif.width_mismatch, vif.frame_changed}), 128'(0));
    check("rst_hist",        128'(vif.hist),        128'(0));

    // reset released in the middle of a frame; that frame must not report
    vif.vsync = 1'b1; tick(4);
    for (int y = 0; y < 7; y++) begin
      if (y == 3) reset = 1'b0;
      drive_line(8, y, 2, 1'b0, dummy, dh);
    end
    vif.vsync = 1'b0; tick(8); vif.vsync = 1'b1;
    check("partial_frame_reports", 128'(n_reports), 128'(0));
    check("hold_after_partial",    128'(vif.frame_count), 128'(0));

    for (int i = 0; i < 10; i++) drive_frame(tbl[i], 1'b1);

    // last line's hsync falls together with vsync: the line still counts
    v = mk(10, 8, -1, 0, 3, 0, 1, 10, 8, 0, 0);
    drive_frame(v, 1'b1);

    // outputs hold between reports
    tick(20);
    check("hold_valid", 128'(vif.frame_valid), 128'(0));
    check("hold_count", 128'(vif.frame_count), 128'(m_cnt));

    for (int k = 0; k < 50 && sb.size() != 0; k++) tick(1);
    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    check("report_total",       128'(n_reports), 128'(11));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
